change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vending_pkg.sv | 18 +
 rtl/handshake_timer.sv | 33 +++
 rtl/change_dispenser.sv | 123 ++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared vending constants: coin values in cents and the change-dispenser state codes.
// The FAULT code exists only when CHANGE_TIMEOUT_EN is defined.
package vending_pkg;

  localparam int unsigned NICKEL  = 5;
  localparam int unsigned DIME    = 10;
  localparam int unsigned QUARTER = 25;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
`ifdef CHANGE_TIMEOUT_EN
  localparam logic [2:0] ST_FAULT   = 3'd5;
`endif

endpackage

// File: rtl/handshake_timer.sv
// Per-phase handshake watchdog; o_expired flags the last permitted cycle of a phase.
// Only built when CHANGE_TIMEOUT_EN is defined.
`ifdef CHANGE_TIMEOUT_EN
module handshake_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Count starts at 0 on the first cycle of a phase, so expiry lands after TIMEOUT_CYCLES cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count == LAST);

endmodule
`endif

// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser driving a quarter/dime/nickel ejector over a four-phase Ack handshake.
// Define CHANGE_TIMEOUT_EN to add the handshake timeout, the sticky FAULT state and the Fault port.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int WIDTH          = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             ClkIn,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] ChangeIn,
  input  logic             Ack,
  output logic             EjectQ,
  output logic             EjectD,
  output logic             EjectN,
  output logic             Busy,
  output logic             Done,
`ifdef CHANGE_TIMEOUT_EN
  output logic             Fault,
`endif
  output logic [WIDTH-1:0] Remaining
);

  localparam logic [WIDTH-1:0] W_NICKEL  = WIDTH'(NICKEL);
  localparam logic [WIDTH-1:0] W_DIME    = WIDTH'(DIME);
  localparam logic [WIDTH-1:0] W_QUARTER = WIDTH'(QUARTER);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [WIDTH-1:0] r_remaining;
  logic [2:0]       r_eject;
  logic [2:0]       w_pick;
  logic [WIDTH-1:0] w_coin;

`ifdef CHANGE_TIMEOUT_EN
  logic w_expired;
  logic w_timer_en;
  logic w_timer_clear;

  assign w_timer_en    = (r_state == ST_REQ) || (r_state == ST_RELEASE);
  assign w_timer_clear = (w_next != r_state);

  handshake_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (ClkIn),
    .i_rst    (Reset),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_en),
    .o_expired(w_expired)
  );
`endif

  // Eject bits are {quarter, dime, nickel}; an all-zero pick means the residue is below a nickel.
  always_comb begin
    w_pick = 3'b000;
    if (r_remaining >= W_QUARTER)     w_pick = 3'b100;
    else if (r_remaining >= W_DIME)   w_pick = 3'b010;
    else if (r_remaining >= W_NICKEL) w_pick = 3'b001;
  end

  always_comb begin
    w_coin = W_NICKEL;
    case (r_eject)
      3'b100:  w_coin = W_QUARTER;
      3'b010:  w_coin = W_DIME;
      default: w_coin = W_NICKEL;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (Start) w_next = ST_SELECT;
      ST_SELECT:  w_next = (w_pick != 3'b000) ? ST_REQ : ST_DONE;
      ST_REQ: begin
        if (Ack) w_next = ST_RELEASE;
`ifdef CHANGE_TIMEOUT_EN
        else if (w_expired) w_next = ST_FAULT;
`endif
      end
      ST_RELEASE: begin
        if (!Ack) w_next = ST_SELECT;
`ifdef CHANGE_TIMEOUT_EN
        else if (w_expired) w_next = ST_FAULT;
`endif
      end
      ST_DONE:    w_next = ST_IDLE;
`ifdef CHANGE_TIMEOUT_EN
      ST_FAULT:   w_next = ST_FAULT;
`endif
      default:    w_next = ST_IDLE;
    endcase
  end

  // The coin is subtracted on the same edge that accepts Ack, so Remaining never leads the ejector.
  always_ff @(posedge ClkIn or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_eject     <= 3'b000;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && Start) r_remaining <= ChangeIn;
      if ((r_state == ST_REQ) && Ack)    r_remaining <= r_remaining - w_coin;
      if (r_state == ST_SELECT)                           r_eject <= w_pick;
      else if ((r_state == ST_REQ) && (w_next != ST_REQ)) r_eject <= 3'b000;
    end
  end

  assign {EjectQ, EjectD, EjectN} = r_eject;
  assign Done      = (r_state == ST_DONE);
  assign Remaining = r_remaining;

`ifdef CHANGE_TIMEOUT_EN
  assign Busy  = (r_state != ST_IDLE) && (r_state != ST_FAULT);
  assign Fault = (r_state == ST_FAULT);
`else
  assign Busy  = (r_state != ST_IDLE);
`endif

endmodule
